// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and mode constants for the raster generator.
package vga_timing_pkg;

  localparam int COORD_W = 12;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    bit           h_pol;
    bit           v_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480_60 = '{
    h: '{active: 640, fp: 16, sync: 96,  bp: 48},
    v: '{active: 480, fp: 10, sync: 2,   bp: 33},
    h_pol: 1'b0, v_pol: 1'b0
  };

  localparam vga_mode_t MODE_800X600_60 = '{
    h: '{active: 800, fp: 40, sync: 128, bp: 88},
    v: '{active: 600, fp: 1,  sync: 4,   bp: 23},
    h_pol: 1'b1, v_pol: 1'b1
  };

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register that lags a sync pulse by DEPTH (>= 1) cycles.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int DEPTH   = 1,
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  sr_q <= {DEPTH{RST_VAL}};
    else if (en_i) sr_q <= sr_d;
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: registered coordinates, active flag, strobes and
// delayed sync pulses for one VGA mode.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE_640X480_60.h.active,
  parameter int H_FP     = MODE_640X480_60.h.fp,
  parameter int H_SYNC   = MODE_640X480_60.h.sync,
  parameter int H_BP     = MODE_640X480_60.h.bp,
  parameter int V_ACTIVE = MODE_640X480_60.v.active,
  parameter int V_FP     = MODE_640X480_60.v.fp,
  parameter int V_SYNC   = MODE_640X480_60.v.sync,
  parameter int V_BP     = MODE_640X480_60.v.bp,
  parameter bit H_POL    = MODE_640X480_60.h_pol,
  parameter bit V_POL    = MODE_640X480_60.v_pol,
  parameter int SYNC_DLY = 1
) (
  input  logic               pix_clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  output logic [COORD_W-1:0] pix_x_o,
  output logic [COORD_W-1:0] pix_y_o,
  output logic               vid_active_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               line_start_o,
  output logic               frame_start_o
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic [COORD_W-1:0] pix_x_q, pix_y_q;
  logic               vid_active_q, line_start_q, frame_start_q;
  logic               hsync_q, vsync_q;
  logic               h_wrap, hsync_raw, vsync_raw;

  always_comb begin
    h_wrap    = (h_cnt_q == H_LAST);
    h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d   = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    hsync_raw = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    vsync_raw = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  end

  // Output registers decode the pre-increment counters, so pix_x/pix_y lag by one.
  always_ff @(posedge pix_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      vid_active_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
    end else if (en_i) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_x_q       <= h_cnt_q;
      pix_y_q       <= v_cnt_q;
      vid_active_q  <= (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      line_start_q  <= (h_cnt_q == '0);
      frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
      hsync_q       <= hsync_raw ? H_POL : ~H_POL;
      vsync_q       <= vsync_raw ? V_POL : ~V_POL;
    end
  end

  generate
    if (SYNC_DLY == 0) begin : g_no_dly
      assign hsync_o = hsync_q;
      assign vsync_o = vsync_q;
    end else begin : g_dly
      sync_delay_line #(.DEPTH(SYNC_DLY), .RST_VAL(~H_POL)) u_hsync_dly (
        .clk_i   (pix_clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .d_i     (hsync_q),
        .q_o     (hsync_o)
      );
      sync_delay_line #(.DEPTH(SYNC_DLY), .RST_VAL(~V_POL)) u_vsync_dly (
        .clk_i   (pix_clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .d_i     (vsync_q),
        .q_o     (vsync_o)
      );
    end
  endgenerate

  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign vid_active_o  = vid_active_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default mode, zero-delay positive
// hsync, and a tiny mode that wraps whole frames quickly) against a raster model.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  initial forever #5 clk = ~clk;

  logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic a_va, a_hs, a_vs, a_ls, a_fs;
  logic b_va, b_hs, b_vs, b_ls, b_fs;
  logic c_va, c_hs, c_vs, c_ls, c_fs;

  vga_sync_gen dut_a (
    .pix_clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .pix_x_o(a_x), .pix_y_o(a_y), .vid_active_o(a_va), .hsync_o(a_hs),
    .vsync_o(a_vs), .line_start_o(a_ls), .frame_start_o(a_fs)
  );

  vga_sync_gen #(.SYNC_DLY(0), .H_POL(1'b1)) dut_b (
    .pix_clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .pix_x_o(b_x), .pix_y_o(b_y), .vid_active_o(b_va), .hsync_o(b_hs),
    .vsync_o(b_vs), .line_start_o(b_ls), .frame_start_o(b_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b1), .SYNC_DLY(3)
  ) dut_c (
    .pix_clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .pix_x_o(c_x), .pix_y_o(c_y), .vid_active_o(c_va), .hsync_o(c_hs),
    .vsync_o(c_vs), .line_start_o(c_ls), .frame_start_o(c_fs)
  );

  typedef struct {
    logic [11:0] x, y;
    logic        va, hs, vs, ls, fs;
  } exp_t;

  int     vectors = 0;
  int     miscompares = 0;
  longint k = 0;  // enabled clock edges since reset released

  // After k enabled edges the outputs show raster position k-1; the sync
  // outputs show position k-1-d, or their idle level before that exists.
  function automatic exp_t ref_model(input longint kk,
                                     input int hact, input int hfp, input int hsw, input int hbp,
                                     input int vact, input int vfp, input int vsw, input int vbp,
                                     input bit hp, input bit vp, input int d);
    exp_t   r;
    longint ht, vt, p, x, y;
    ht   = hact + hfp + hsw + hbp;
    vt   = vact + vfp + vsw + vbp;
    r.x  = '0;
    r.y  = '0;
    r.va = 1'b0;
    r.ls = 1'b0;
    r.fs = 1'b0;
    r.hs = ~hp;
    r.vs = ~vp;
    if (kk >= 1) begin
      p    = (kk - 1) % (ht * vt);
      x    = p % ht;
      y    = p / ht;
      r.x  = 12'(x);
      r.y  = 12'(y);
      r.va = (x < hact) && (y < vact);
      r.ls = (x == 0);
      r.fs = (p == 0);
    end
    if (kk - 1 - d >= 0) begin
      p    = (kk - 1 - d) % (ht * vt);
      x    = p % ht;
      y    = p / ht;
      r.hs = (x >= hact + hfp && x < hact + hfp + hsw) ? hp : ~hp;
      r.vs = (y >= vact + vfp && y < vact + vfp + vsw) ? vp : ~vp;
    end
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t, k=%0d)", tag, obs, exp, $time, k);
      $error("check %s disagreed", tag);
    end
  endtask

  task automatic chk_dut(input string n, input exp_t e,
                         input logic [11:0] x, input logic [11:0] y,
                         input logic va, input logic hs, input logic vs,
                         input logic ls, input logic fs);
    cmp({n, ".pix_x"},       x,       e.x);
    cmp({n, ".pix_y"},       y,       e.y);
    cmp({n, ".vid_active"},  12'(va), 12'(e.va));
    cmp({n, ".hsync"},       12'(hs), 12'(e.hs));
    cmp({n, ".vsync"},       12'(vs), 12'(e.vs));
    cmp({n, ".line_start"},  12'(ls), 12'(e.ls));
    cmp({n, ".frame_start"}, 12'(fs), 12'(e.fs));
  endtask

  task automatic check_all();
    chk_dut("a", ref_model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1),
            a_x, a_y, a_va, a_hs, a_vs, a_ls, a_fs);
    chk_dut("b", ref_model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b0, 0),
            b_x, b_y, b_va, b_hs, b_vs, b_ls, b_fs);
    chk_dut("c", ref_model(k, 10, 2, 3, 5, 6, 1, 2, 3, 1'b0, 1'b1, 3),
            c_x, c_y, c_va, c_hs, c_vs, c_ls, c_fs);
  endtask

  task automatic step();
    logic live;
    @(posedge clk);
    live = rst_n && en;
    #1;
    if (live) k++;
    check_all();
  endtask

  // Asynchronous reset mid-cycle: outputs must settle before any clock edge.
  task automatic do_reset(input int hold_cycles);
    rst_n = 1'b0;
    #1;
    k = 0;
    check_all();
    repeat (hold_cycles) step();
    rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    rst_n = 1'b1;
    en    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    k = 0;
    check_all();
    repeat (3) step();
    rst_n = 1'b1;

    step();
    cmp("first_edge.pix_x", a_x, 12'd0);
    cmp("first_edge.frame_start", 12'(a_fs), 12'd1);
    cmp("first_edge.vid_active", 12'(a_va), 12'd1);

    repeat (1700) step();

    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (a_x == 12'd300) found = 1'b1;
      else step();
    end
    cmp("reach_x300", 12'(found), 12'd1);
    en = 1'b0;
    repeat (10) step();
    cmp("hold_x", a_x, 12'd300);
    en = 1'b1;
    step();
    cmp("hold_resume_x", a_x, 12'd301);

    repeat (600) begin
      en = ($urandom_range(0, 7) != 0);
      step();
    end
    en = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (a_x == 12'd400) found = 1'b1;
      else step();
    end
    cmp("reach_x400", 12'(found), 12'd1);
    do_reset(2);
    cmp("midline_reset.hsync", 12'(a_hs), 12'd1);
    step();
    cmp("restart.pix_x", a_x, 12'd0);
    cmp("restart.pix_y", a_y, 12'd0);
    cmp("restart.frame_start", 12'(a_fs), 12'd1);

    repeat (3000) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 599) == 0) begin
        do_reset(int'($urandom_range(0, 3)));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator that sits directly upstream of the character pixel generator.
- Produces the pixel coordinates (pix_x, pix_y), the active-video flag, and the hsync/vsync pulses for one VGA mode.
- Sync outputs pass through a programmable delay line. This aligns them with the downstream colour path, which lags coordinates by the char ROM read latency.
- Also emits line_start and frame_start strobes for character-position update logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
SYNC_DLY, 1, extra pix_clk cycles of delay on hsync/vsync (range 0..7)

Ports:
pix_clk     input   1   pixel clock; all logic on its rising edge
rst_n       input   1   asynchronous active-low reset
en          input   1   count enable; low freezes counters and all outputs
pix_x       output  12  current column, 0..H_TOTAL-1
pix_y       output  12  current line, 0..V_TOTAL-1
vid_active  output  1   high when pix_x < H_ACTIVE and pix_y < V_ACTIVE
hsync       output  1   horizontal sync at H_POL level, delayed SYNC_DLY cycles
vsync       output  1   vertical sync at V_POL level, delayed SYNC_DLY cycles
line_start  output  1   one-cycle pulse when pix_x == 0
frame_start output  1   one-cycle pulse when pix_x == 0 and pix_y == 0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL likewise (525 by default). Both must be at most 4096.
- Internal counters: h_cnt and v_cnt, 12 bits each, unsigned.
- Counter stepping, on each edge with en = 1:
  - h_cnt wraps from H_TOTAL-1 to 0, otherwise increments.
  - v_cnt increments only on the h_cnt wrap, and wraps from V_TOTAL-1 to 0 on that same edge.
- Output registers load the decode of the pre-increment (h_cnt, v_cnt) on the same edge, so every output is registered with zero combinational paths. pix_x/pix_y equal the counter value of the previous cycle.
- Decode equations:
  - hsync_raw is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync_raw is active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - vsync changes only on line boundaries, aligned with the pix_x = 0 cycle.
- Sync delay line:
  - hsync/vsync pass through a SYNC_DLY-deep shift register after the output register.
  - SYNC_DLY = 0 means no extra stage.
  - pix_x, pix_y, vid_active, line_start and frame_start are never delayed.
- Reset (async assert, any time, including mid-line):
  - h_cnt = v_cnt = 0; pix_x = pix_y = 0.
  - vid_active = line_start = frame_start = 0.
  - hsync = ~H_POL and vsync = ~V_POL, including every delay-line stage.
- First edge after rst_n deasserts (en = 1): pix_x = 0, pix_y = 0, vid_active = 1, line_start = 1, frame_start = 1; h_cnt becomes 1.
- en = 0: counters, output registers and delay line all hold; strobes hold their value.
  - en is intended to be static. A pulse stalled high for multiple cycles is legal and is not filtered.
- Boundaries:
  - At pix_x = H_ACTIVE-1, vid_active is still 1; it drops to 0 on the next cycle.
  - At (H_TOTAL-1, V_TOTAL-1) the next cycle is (0,0) with frame_start = 1.
  - Lines V_ACTIVE..V_TOTAL-1 have vid_active = 0 for all pix_x, but line_start still pulses.

Decomposition:
- Shared package vga_timing_pkg holds:
  - mode constants for 640x480@60 and 800x600@60;
  - the 12-bit coordinate width constant;
  - a function computing the totals.
- One natural sub-module: sync_delay_line, a parameterised-depth shift register with a reset value parameter. It is instantiated once for hsync and once for vsync.

Test Plan:
1. Reset, then release with en = 1 -> first edge gives pix_x = 0, pix_y = 0, vid_active = 1, frame_start = 1; hsync = vsync = 1 throughout reset (default polarity).
2. Free-run one line -> vid_active high for exactly 640 cycles. With SYNC_DLY = 1, hsync is low for exactly 96 cycles, starting one cycle after pix_x = 656 and ending one cycle after pix_x = 751. pix_x wraps 799 -> 0 with line_start = 1.
3. Free-run a full frame -> exactly 420000 cycles between frame_start pulses. vsync is low for 1600 cycles, aligned to the lines where pix_y = 490..491. pix_y wraps 524 -> 0.
4. Hold en = 0 for 10 cycles at pix_x = 300 -> all outputs are constant; after en returns to 1 the next cycle shows pix_x = 301.
5. Assert rst_n low at pix_x = 400, pix_y = 200 -> all outputs immediately take reset values, without waiting for a clock edge; on release, restart at (0,0).
6. Rebuild with SYNC_DLY = 0, H_POL = 1 -> hsync is high when pix_x = 656..751 with no extra lag; vid_active and line_start timing are identical to scenario 2.
